// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and sizing helpers for the PLL lock sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    PRST   = 3'd0,
    WLOCK  = 3'd1,
    STABLE = 3'd2,
    REL    = 3'd3,
    LOSS   = 3'd4,
    RUN    = 3'd5
  } state_e;

  localparam int LOSS_W = 8;

  // Width of the shared down-counter: enough bits to hold the largest reload value.
  function automatic int cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  // Width of the release index; never below one bit so a single-domain build still elaborates.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchroniser with asynchronous active-low clear to 0
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of an asynchronous level; both stages clear to 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - PLL reset pulse, lock qualification and staged domain-reset release
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NRST       = 3,
  parameter int RST_CYC    = 16,
  parameter int LOCK_TMO   = 65535,
  parameter int STABLE_CYC = 1024,
  parameter int STAGE_GAP  = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pll_locked,
  output logic              pll_rst,
  output logic [NRST-1:0]   rst_out_n,
  output logic              ready,
  output logic              tmo_err,
  output logic [LOSS_W-1:0] loss_cnt
);

  localparam int CW = cnt_width(RST_CYC, LOCK_TMO, STABLE_CYC, STAGE_GAP);
  localparam int IW = idx_width(NRST);

  localparam logic [CW-1:0]   RST_LD    = CW'(RST_CYC - 1);
  localparam logic [CW-1:0]   LOCK_LD   = CW'(LOCK_TMO - 1);
  localparam logic [CW-1:0]   STABLE_LD = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0]   GAP_LD    = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(NRST - 1);
  localparam logic [NRST-1:0] FIRST_BIT = NRST'(1);
  localparam logic [LOSS_W-1:0] LOSS_MAX = {LOSS_W{1'b1}};

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [IW-1:0]     idx_inc;
  logic              pll_rst_q, pll_rst_d;
  logic [NRST-1:0]   rst_n_q, rst_n_d;
  logic              ready_q, ready_d;
  logic              tmo_q, tmo_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
  logic              lk;

  // Qualified lock: pll_locked is asynchronous to the reference clock.
  sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rstn),
    .d_i   (pll_locked),
    .q_o   (lk)
  );

  assign idx_inc = idx_q + 1'b1;

  // State register; the sequence always restarts from PRST after rstn.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= PRST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a lock drop takes priority over counter expiry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PRST: begin
        if (cnt_q == '0) state_d = WLOCK;
      end
      WLOCK: begin
        if (lk)                 state_d = STABLE;
        else if (cnt_q == '0)   state_d = PRST;
      end
      STABLE: begin
        if (!lk)                state_d = WLOCK;
        else if (cnt_q == '0)   state_d = REL;
      end
      REL: begin
        if (!lk)                    state_d = LOSS;
        else if (idx_q == IDX_LAST) state_d = RUN;
      end
      RUN: begin
        if (!lk) state_d = LOSS;
      end
      LOSS: begin
        state_d = PRST;
      end
      default: begin
        state_d = PRST;
      end
    endcase
  end

  // Next values of the counter, release index and every registered output.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_n_d   = rst_n_q;
    tmo_d     = tmo_q;
    loss_d    = loss_q;
    pll_rst_d = (state_d == PRST);
    ready_d   = (state_d == RUN);

    if (state_d != state_q) begin
      case (state_d)
        PRST:    cnt_d = RST_LD;
        WLOCK:   cnt_d = LOCK_LD;
        STABLE:  cnt_d = STABLE_LD;
        REL:     cnt_d = GAP_LD;
        default: cnt_d = '0;
      endcase
    end else if (state_q == REL && cnt_q == '0) begin
      cnt_d = GAP_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end

    case (state_d)
      REL: begin
        if (state_q != REL) begin
          rst_n_d = FIRST_BIT;
          idx_d   = '0;
        end else if (cnt_q == '0) begin
          rst_n_d = rst_n_q | (FIRST_BIT << idx_inc);
          idx_d   = idx_inc;
        end
      end
      RUN:     rst_n_d = rst_n_q;
      default: rst_n_d = '0;
    endcase

    if (state_q == WLOCK && state_d == PRST) begin
      tmo_d = 1'b1;
    end

    if (state_q == RUN && state_d == LOSS && loss_q != LOSS_MAX) begin
      loss_d = loss_q + 1'b1;
    end
  end

  // Datapath and output flops; cnt resets to the PRST load so the first attempt is a full pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q     <= RST_LD;
      idx_q     <= '0;
      pll_rst_q <= 1'b1;
      rst_n_q   <= '0;
      ready_q   <= 1'b0;
      tmo_q     <= 1'b0;
      loss_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pll_rst_q <= pll_rst_d;
      rst_n_q   <= rst_n_d;
      ready_q   <= ready_d;
      tmo_q     <= tmo_d;
      loss_q    <= loss_d;
    end
  end

  assign pll_rst   = pll_rst_q;
  assign rst_out_n = rst_n_q;
  assign ready     = ready_q;
  assign tmo_err   = tmo_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - self-checking bench for pll_lock_sequencer
module tb_pll_lock_sequencer;

  localparam int NRST       = 3;
  localparam int RST_CYC    = 4;
  localparam int LOCK_TMO   = 20;
  localparam int STABLE_CYC = 8;
  localparam int STAGE_GAP  = 5;

  logic            clk = 1'b0;
  logic            rstn;
  logic            pll_locked;
  logic            pll_rst;
  logic [NRST-1:0] rst_out_n;
  logic            ready;
  logic            tmo_err;
  logic [7:0]      loss_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef enum int {M_PRST, M_WLOCK, M_STABLE, M_REL, M_RUN, M_LOSS} mphase_t;
  mphase_t m_phase;
  int      m_t, m_rel, m_loss;
  bit      m_tmo, m_s1, m_lk;

  pll_lock_sequencer #(
    .NRST(NRST), .RST_CYC(RST_CYC), .LOCK_TMO(LOCK_TMO),
    .STABLE_CYC(STABLE_CYC), .STAGE_GAP(STAGE_GAP)
  ) dut (
    .clk(clk), .rstn(rstn), .pll_locked(pll_locked), .pll_rst(pll_rst),
    .rst_out_n(rst_out_n), .ready(ready), .tmo_err(tmo_err), .loss_cnt(loss_cnt)
  );

  always #20 clk = ~clk;

  task automatic model_reset();
    m_phase = M_PRST; m_t = 0; m_rel = 0; m_loss = 0;
    m_tmo = 0; m_s1 = 0; m_lk = 0;
  endtask

  // Behavioural model: phases with elapsed-cycle counts and a count of released domains.
  task automatic model_step();
    bit lk_now;
    lk_now = m_lk;
    m_lk   = m_s1;
    m_s1   = pll_locked;
    case (m_phase)
      M_PRST:   if (m_t + 1 >= RST_CYC) begin m_phase = M_WLOCK; m_t = 0; end else m_t++;
      M_WLOCK:  if (lk_now) begin m_phase = M_STABLE; m_t = 0; end
                else if (m_t + 1 >= LOCK_TMO) begin m_tmo = 1; m_phase = M_PRST; m_t = 0; end
                else m_t++;
      M_STABLE: if (!lk_now) begin m_phase = M_WLOCK; m_t = 0; end
                else if (m_t + 1 >= STABLE_CYC) begin m_phase = M_REL; m_t = 0; m_rel = 1; end
                else m_t++;
      M_REL:    if (!lk_now) begin m_phase = M_LOSS; m_t = 0; m_rel = 0; end
                else if (m_rel == NRST) begin m_phase = M_RUN; m_t = 0; end
                else if (m_t + 1 >= STAGE_GAP) begin m_rel++; m_t = 0; end
                else m_t++;
      M_RUN:    if (!lk_now) begin
                  m_phase = M_LOSS; m_t = 0; m_rel = 0;
                  if (m_loss < 255) m_loss++;
                end
      default:  begin m_phase = M_PRST; m_t = 0; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input bit lock_val);
    @(negedge clk);
    rstn = 1'b0;
    pll_locked = lock_val;
    model_reset();
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    cyc = 0;
  endtask

  // Immediate-lock PLL: lock follows pll_rst release; returns first bit-0 release and ready cycles.
  task automatic bring_up(output int t_rel0, output int t_rdy);
    t_rel0 = -1; t_rdy = -1;
    do_reset(1'b0);
    for (int i = 0; i < 100 && t_rdy < 0; i++) begin
      tick();
      if (t_rel0 < 0 && rst_out_n === 3'b001) t_rel0 = cyc;
      if (ready === 1'b1) t_rdy = cyc;
      pll_locked = !pll_rst;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rstn = 1'b0;
    pll_locked = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL reset_pll_rst: got %b want 1", pll_rst); end
    n_tests++; if (rst_out_n !== 3'b000) begin n_fail++; $display("FAIL reset_rst_out_n: got %b want 000", rst_out_n); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", ready); end
    n_tests++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL reset_tmo_err: got %b want 0", tmo_err); end
    n_tests++; if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_loss_cnt: got %0d want 0", loss_cnt); end
    rstn = 1'b1;
  endtask

  task automatic test_bringup();
    int fall, t1, t2, t3, trdy;
    bit order_ok;
    fall = -1; t1 = -1; t2 = -1; t3 = -1; trdy = -1; order_ok = 1;
    do_reset(1'b0);
    for (int i = 0; i < 60; i++) begin
      tick();
      if (fall < 0 && pll_rst === 1'b0) fall = cyc;
      if (fall >= 0 && cyc == fall + 3) pll_locked = 1'b1;
      if (!(rst_out_n inside {3'b000, 3'b001, 3'b011, 3'b111})) order_ok = 0;
      if (t1 < 0 && rst_out_n === 3'b001) t1 = cyc;
      if (t2 < 0 && rst_out_n === 3'b011) t2 = cyc;
      if (t3 < 0 && rst_out_n === 3'b111) t3 = cyc;
      if (trdy < 0 && ready === 1'b1) trdy = cyc;
    end
    n_tests++; if (fall != RST_CYC) begin n_fail++; $display("FAIL bringup_pll_rst_fall: got %0d want %0d", fall, RST_CYC); end
    n_tests++; if (t1 != RST_CYC + 3 + 3 + STABLE_CYC) begin n_fail++; $display("FAIL bringup_rel0: got %0d want %0d", t1, RST_CYC + 6 + STABLE_CYC); end
    n_tests++; if (t2 != t1 + STAGE_GAP) begin n_fail++; $display("FAIL bringup_rel1: got %0d want %0d", t2, t1 + STAGE_GAP); end
    n_tests++; if (t3 != t1 + 2 * STAGE_GAP) begin n_fail++; $display("FAIL bringup_rel2: got %0d want %0d", t3, t1 + 2 * STAGE_GAP); end
    n_tests++; if (trdy != t3 + 1) begin n_fail++; $display("FAIL bringup_ready: got %0d want %0d", trdy, t3 + 1); end
    n_tests++; if (!order_ok) begin n_fail++; $display("FAIL bringup_order: got non-ascending pattern want 000/001/011/111"); end
    n_tests++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL bringup_tmo_err: got %b want 0", tmo_err); end
  endtask

  task automatic test_timeout();
    bit e_rst, e_tmo;
    do_reset(1'b0);
    for (int i = 0; i < 60; i++) begin
      tick();
      e_rst = (cyc < RST_CYC) ? 1'b1 : (((cyc - RST_CYC) % (RST_CYC + LOCK_TMO)) >= LOCK_TMO);
      e_tmo = (cyc >= RST_CYC + LOCK_TMO);
      n_tests++; if (pll_rst !== e_rst) begin n_fail++; $display("FAIL timeout_pll_rst@%0d: got %b want %b", cyc, pll_rst, e_rst); end
      n_tests++; if (tmo_err !== e_tmo) begin n_fail++; $display("FAIL timeout_tmo_err@%0d: got %b want %b", cyc, tmo_err, e_tmo); end
      n_tests++; if (rst_out_n !== 3'b000) begin n_fail++; $display("FAIL timeout_rst_out_n@%0d: got %b want 000", cyc, rst_out_n); end
    end
  endtask

  task automatic test_glitch();
    int t1;
    bit early;
    t1 = -1; early = 0;
    do_reset(1'b1);
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cyc == 7) pll_locked = 1'b0;
      if (cyc == 8) pll_locked = 1'b1;
      if (cyc <= 18 && rst_out_n !== 3'b000) early = 1;
      if (t1 < 0 && rst_out_n === 3'b001) t1 = cyc;
    end
    n_tests++; if (early) begin n_fail++; $display("FAIL glitch_early_release: got release before 19 want none"); end
    n_tests++; if (t1 != 11 + STABLE_CYC) begin n_fail++; $display("FAIL glitch_rel0: got %0d want %0d", t1, 11 + STABLE_CYC); end
  endtask

  task automatic test_loss_run();
    int t0, tr, d;
    bring_up(t0, tr);
    n_tests++; if (t0 != RST_CYC + 2 + 1 + STABLE_CYC) begin n_fail++; $display("FAIL release_timing: got %0d want %0d", t0, RST_CYC + 3 + STABLE_CYC); end
    n_tests++; if (tr != t0 + 2 * STAGE_GAP + 1) begin n_fail++; $display("FAIL run_ready_time: got %0d want %0d", tr, t0 + 2 * STAGE_GAP + 1); end
    repeat (2) tick();
    d = cyc;
    pll_locked = 1'b0;
    repeat (2) begin
      tick();
      n_tests++; if (ready !== 1'b1 || rst_out_n !== 3'b111) begin n_fail++; $display("FAIL loss_run_hold@+%0d: got ready=%b rst=%b want 1/111", cyc - d, ready, rst_out_n); end
    end
    tick();
    n_tests++; if (rst_out_n !== 3'b000 || ready !== 1'b0) begin n_fail++; $display("FAIL loss_run_drop: got ready=%b rst=%b want 0/000", ready, rst_out_n); end
    n_tests++; if (loss_cnt !== 8'd1) begin n_fail++; $display("FAIL loss_run_cnt: got %0d want 1", loss_cnt); end
    tick();
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL loss_run_prst: got %b want 1", pll_rst); end
  endtask

  task automatic test_loss_rel();
    int d;
    d = -1;
    do_reset(1'b0);
    for (int i = 0; i < 60 && d < 0; i++) begin
      tick();
      if (rst_out_n === 3'b011) d = cyc;
      else pll_locked = !pll_rst;
    end
    n_tests++; if (d != RST_CYC + 3 + STABLE_CYC + STAGE_GAP) begin n_fail++; $display("FAIL loss_rel_reach: got %0d want %0d", d, RST_CYC + 3 + STABLE_CYC + STAGE_GAP); end
    pll_locked = 1'b0;
    repeat (2) tick();
    n_tests++; if (rst_out_n !== 3'b011) begin n_fail++; $display("FAIL loss_rel_hold: got %b want 011", rst_out_n); end
    tick();
    n_tests++; if (rst_out_n !== 3'b000 || ready !== 1'b0) begin n_fail++; $display("FAIL loss_rel_drop: got rst=%b ready=%b want 000/0", rst_out_n, ready); end
    n_tests++; if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL loss_rel_cnt: got %0d want 0", loss_cnt); end
  endtask

  task automatic test_saturation();
    int losses;
    bit drop, prev_rdy, done;
    losses = 0; drop = 0; prev_rdy = 0; done = 0;
    do_reset(1'b0);
    for (int i = 0; i < 260 * 40 && losses < 260; i++) begin
      tick();
      if (prev_rdy && !ready) begin
        losses++;
        if (losses == 100) begin
          n_tests++; if (loss_cnt !== 8'd100) begin n_fail++; $display("FAIL sat_mid_cnt: got %0d want 100", loss_cnt); end
        end
        if (losses == 255) begin
          n_tests++; if (loss_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255_cnt: got %0d want 255", loss_cnt); end
        end
      end
      prev_rdy = ready;
      if (ready) drop = 1;
      else if (pll_rst) drop = 0;
      pll_locked = drop ? 1'b0 : !pll_rst;
    end
    n_tests++; if (losses != 260) begin n_fail++; $display("FAIL sat_losses_seen: got %0d want 260", losses); end
    n_tests++; if (loss_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_final_cnt: got %0d want 255", loss_cnt); end
    for (int i = 0; i < 100 && !done; i++) begin
      tick();
      if (rst_out_n === 3'b001) done = 1;
      else pll_locked = !pll_rst;
    end
    n_tests++; if (!done) begin n_fail++; $display("FAIL async_reach_rel: got no REL want rst_out_n=001"); end
    #5;
    rstn = 1'b0;
    #1;
    n_tests++; if (pll_rst !== 1'b1) begin n_fail++; $display("FAIL async_pll_rst: got %b want 1", pll_rst); end
    n_tests++; if (rst_out_n !== 3'b000) begin n_fail++; $display("FAIL async_rst_out_n: got %b want 000", rst_out_n); end
    n_tests++; if (loss_cnt !== 8'd0) begin n_fail++; $display("FAIL async_loss_cnt: got %0d want 0", loss_cnt); end
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL async_ready: got %b want 0", ready); end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    cyc = 0;
  endtask

  task automatic test_random();
    int seg;
    logic [NRST-1:0] e_rst;
    seg = 0;
    do_reset(1'b0);
    for (int i = 0; i < 3000; i++) begin
      if (seg == 0) begin
        if ($urandom_range(0, 3) != 0) begin
          pll_locked = 1'b1; seg = $urandom_range(1, 60);
        end else begin
          pll_locked = 1'b0; seg = ($urandom_range(0, 9) == 0) ? $urandom_range(15, 50) : $urandom_range(1, 6);
        end
      end
      seg--;
      if ($urandom_range(0, 499) == 0) begin
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
      end
      tick();
      e_rst = NRST'((1 << m_rel) - 1);
      n_tests++; if (pll_rst !== (m_phase == M_PRST)) begin n_fail++; $display("FAIL rand_pll_rst@%0d: got %b want %b", i, pll_rst, m_phase == M_PRST); end
      n_tests++; if (rst_out_n !== e_rst) begin n_fail++; $display("FAIL rand_rst_out_n@%0d: got %b want %b", i, rst_out_n, e_rst); end
      n_tests++; if (ready !== (m_phase == M_RUN)) begin n_fail++; $display("FAIL rand_ready@%0d: got %b want %b", i, ready, m_phase == M_RUN); end
      n_tests++; if (tmo_err !== m_tmo) begin n_fail++; $display("FAIL rand_tmo_err@%0d: got %b want %b", i, tmo_err, m_tmo); end
      n_tests++; if (loss_cnt !== 8'(m_loss)) begin n_fail++; $display("FAIL rand_loss_cnt@%0d: got %0d want %0d", i, loss_cnt, m_loss); end
    end
  endtask

  initial begin
    #2400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    pll_locked = 1'b0;
    model_reset();
    test_reset();
    test_bringup();
    test_timeout();
    test_glitch();
    test_loss_run();
    test_loss_rel();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
